// File: rtl/ex_sched_pkg.sv
// Shared types and constants for the execute-stage scheduler.
// Holds opcode encodings, unit/state enums and the decode payload struct.
package ex_sched_pkg;

    localparam int unsigned OPC_W = 5;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned RET_W = 32;

    localparam int unsigned MUL_LAT_DEF  = 3;
    localparam int unsigned DIV_LAT_DEF  = 8;
    localparam int unsigned FADD_LAT_DEF = 4;
    localparam int unsigned FMUL_LAT_DEF = 4;
    localparam int unsigned FDIV_LAT_DEF = 12;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned LAT_MAX = max2(max2(max2(MUL_LAT_DEF, DIV_LAT_DEF),
                                                max2(FADD_LAT_DEF, FMUL_LAT_DEF)),
                                           FDIV_LAT_DEF);
    localparam int unsigned CNT_W = $clog2(LAT_MAX + 1);

    // Logic group 00000-00111
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00001;
    localparam logic [OPC_W-1:0] OP_XOR  = 5'b00010;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SLL  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SRL  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SRA  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_NOR  = 5'b00111;
    // Control group 01000-01110
    localparam logic [OPC_W-1:0] OP_JMP  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_JAL  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_BEQ  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_BNE  = 5'b01100;
    localparam logic [OPC_W-1:0] OP_BLT  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_BGE  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_UND0 = 5'b01111;
    // Move / memory group 10000-10011
    localparam logic [OPC_W-1:0] OP_MOV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_MOVI = 5'b10001;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b10011;
    // Floating point 10100-10111
    localparam logic [OPC_W-1:0] OP_FADD = 5'b10100;
    localparam logic [OPC_W-1:0] OP_FSUB = 5'b10101;
    localparam logic [OPC_W-1:0] OP_FMUL = 5'b10110;
    localparam logic [OPC_W-1:0] OP_FDIV = 5'b10111;
    // Integer arithmetic 11000-11101
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b11000;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b11001;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b11011;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b11100;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b11101;
    localparam logic [OPC_W-1:0] OP_UND1 = 5'b11110;
    localparam logic [OPC_W-1:0] OP_UND2 = 5'b11111;

    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_ALU  = 2'd1,
        UNIT_FPU  = 2'd2
    } unit_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        unit_e            unit;
        logic [CNT_W-1:0] lat;
        logic             we;
    } dec_t;

    // Latencies below one are treated as single-cycle.
    function automatic logic [CNT_W-1:0] lat_cnt(input int unsigned l);
        return (l < 1) ? CNT_W'(1) : CNT_W'(l);
    endfunction

endpackage

// File: rtl/ex_sched_if.sv
// Decode-side and writeback-side handshakes of the execute scheduler.
// master = decode/writeback environment, slave = scheduler.
interface ex_sched_if;
    import ex_sched_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [OPC_W-1:0] in_opcode;
    logic [RD_W-1:0]  in_rd;
    logic             unit_start;
    unit_e            unit_sel;
    logic [OPC_W-1:0] unit_opcode;
    logic             out_valid;
    logic             out_ready;
    logic [RD_W-1:0]  out_rd;
    logic             out_we;
    logic             busy;
    logic [RET_W-1:0] retired;

    modport master (
        output flush, in_valid, in_opcode, in_rd, out_ready,
        input  in_ready, unit_start, unit_sel, unit_opcode,
               out_valid, out_rd, out_we, busy, retired
    );

    modport slave (
        input  flush, in_valid, in_opcode, in_rd, out_ready,
        output in_ready, unit_start, unit_sel, unit_opcode,
               out_valid, out_rd, out_we, busy, retired
    );
endinterface

// File: rtl/ex_lat_decode.sv
// Opcode classifier: selects execution unit, fixed latency and
// register-file write enable for one decoded instruction.
module ex_lat_decode
    import ex_sched_pkg::*;
#(
    parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned FADD_LAT = FADD_LAT_DEF,
    parameter int unsigned FMUL_LAT = FMUL_LAT_DEF,
    parameter int unsigned FDIV_LAT = FDIV_LAT_DEF
) (
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec_c
);

    always_comb begin
        dec_c.unit = UNIT_ALU;
        dec_c.lat  = CNT_W'(1);
        dec_c.we   = 1'b1;
        case (opcode)
            OP_MUL:           dec_c.lat = lat_cnt(MUL_LAT);
            OP_DIV:           dec_c.lat = lat_cnt(DIV_LAT);
            OP_FADD, OP_FSUB: begin
                dec_c.unit = UNIT_FPU;
                dec_c.lat  = lat_cnt(FADD_LAT);
            end
            OP_FMUL: begin
                dec_c.unit = UNIT_FPU;
                dec_c.lat  = lat_cnt(FMUL_LAT);
            end
            OP_FDIV: begin
                dec_c.unit = UNIT_FPU;
                dec_c.lat  = lat_cnt(FDIV_LAT);
            end
            // Control flow and stores produce no register result.
            OP_JMP, OP_JAL, OP_JR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_ST: begin
                dec_c.we = 1'b0;
            end
            OP_UND0, OP_UND1, OP_UND2: begin
                dec_c.unit = UNIT_NONE;
                dec_c.we   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_sched.sv
// Single-entry execute scheduler: accepts one instruction, issues it to
// ALU/FPU, counts out its latency and hands the completion to writeback.
module ex_sched
    import ex_sched_pkg::*;
#(
    parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned FADD_LAT = FADD_LAT_DEF,
    parameter int unsigned FMUL_LAT = FMUL_LAT_DEF,
    parameter int unsigned FDIV_LAT = FDIV_LAT_DEF
) (
    input logic       clk,
    input logic       reset,
    ex_sched_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic             we_q, we_d;
    logic             unit_start_q, unit_start_d;
    unit_e            unit_sel_q, unit_sel_d;
    logic [OPC_W-1:0] unit_opcode_q, unit_opcode_d;
    logic             out_valid_q, out_valid_d;
    logic [RD_W-1:0]  out_rd_q, out_rd_d;
    logic             out_we_q, out_we_d;
    logic             busy_q, busy_d;
    logic [RET_W-1:0] retired_q, retired_d;

    dec_t dec_c;
    logic in_ready_c;
    logic accept_c;
    logic out_fire_c;

    ex_lat_decode #(
        .MUL_LAT  (MUL_LAT),
        .DIV_LAT  (DIV_LAT),
        .FADD_LAT (FADD_LAT),
        .FMUL_LAT (FMUL_LAT),
        .FDIV_LAT (FDIV_LAT)
    ) u_dec (
        .opcode (bus.in_opcode),
        .dec_c  (dec_c)
    );

    // Ready is combinational so a held completion can retire and a new
    // instruction enter in the same cycle.
    assign in_ready_c = !bus.flush &&
                        ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept_c   = bus.in_valid && in_ready_c;
    assign out_fire_c = (state_q == DONE) && bus.out_ready && !bus.flush;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        we_d          = we_q;
        unit_start_d  = 1'b0;
        unit_sel_d    = unit_sel_q;
        unit_opcode_d = unit_opcode_q;
        retired_d     = retired_q;

        if (bus.flush) begin
            state_d       = IDLE;
            cnt_d         = '0;
            unit_sel_d    = UNIT_NONE;
            unit_opcode_d = '0;
        end else begin
            case (state_q)
                EXEC: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE:    if (bus.out_ready) state_d = IDLE;
                default: ;
            endcase

            if (out_fire_c) retired_d = retired_q + RET_W'(1);

            if (accept_c) begin
                unit_start_d  = 1'b1;
                unit_sel_d    = dec_c.unit;
                unit_opcode_d = bus.in_opcode;
                rd_d          = bus.in_rd;
                we_d          = dec_c.we;
                if (dec_c.lat > CNT_W'(1)) begin
                    state_d = EXEC;
                    cnt_d   = dec_c.lat - CNT_W'(1);
                end else begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
        end

        // Completion outputs mirror the next state so they appear registered.
        out_valid_d = (state_d == DONE);
        out_rd_d    = out_valid_d ? rd_d : '0;
        out_we_d    = out_valid_d && we_d;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rd_q          <= '0;
            we_q          <= 1'b0;
            unit_start_q  <= 1'b0;
            unit_sel_q    <= UNIT_NONE;
            unit_opcode_q <= '0;
            out_valid_q   <= 1'b0;
            out_rd_q      <= '0;
            out_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            we_q          <= we_d;
            unit_start_q  <= unit_start_d;
            unit_sel_q    <= unit_sel_d;
            unit_opcode_q <= unit_opcode_d;
            out_valid_q   <= out_valid_d;
            out_rd_q      <= out_rd_d;
            out_we_q      <= out_we_d;
            busy_q        <= busy_d;
            retired_q     <= retired_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.unit_start  = unit_start_q;
    assign bus.unit_sel    = unit_sel_q;
    assign bus.unit_opcode = unit_opcode_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_we      = out_we_q;
    assign bus.busy        = busy_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_ex_sched.sv
// Directed bench for ex_sched: single-cycle, long-latency, stalled
// writeback, back-to-back, flush, we decode, retired wrap and reset.
module tb_ex_sched;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ex_sched_if bus ();

    ex_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] opc, input logic [4:0] rd);
        bus.in_valid  = 1'b1;
        bus.in_opcode = opc;
        bus.in_rd     = rd;
    endtask

    logic [4:0] t_opc [3];
    logic [4:0] t_rd  [3];
    logic [1:0] t_sel [3];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 5'd0;
        bus.in_rd     = 5'd0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_out_valid",  32'(bus.out_valid),   32'd0);
        check("rst_unit_start", 32'(bus.unit_start),  32'd0);
        check("rst_unit_sel",   32'(bus.unit_sel),    32'd0);
        check("rst_unit_opc",   32'(bus.unit_opcode), 32'd0);
        check("rst_out_rd",     32'(bus.out_rd),      32'd0);
        check("rst_out_we",     32'(bus.out_we),      32'd0);
        check("rst_busy",       32'(bus.busy),        32'd0);
        check("rst_retired",    bus.retired,          32'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready",   32'(bus.in_ready),    32'd1);

        // add, single cycle, writeback ready
        bus.out_ready = 1'b1;
        offer(5'b11000, 5'd3);
        tick();
        bus.in_valid = 1'b0;
        check("add_unit_start", 32'(bus.unit_start),  32'd1);
        check("add_unit_sel",   32'(bus.unit_sel),    32'd1);
        check("add_unit_opc",   32'(bus.unit_opcode), 32'h18);
        check("add_out_valid",  32'(bus.out_valid),   32'd1);
        check("add_out_rd",     32'(bus.out_rd),      32'd3);
        check("add_out_we",     32'(bus.out_we),      32'd1);
        tick();
        check("add_retired",    bus.retired,          32'd1);
        check("add_valid_drop", 32'(bus.out_valid),   32'd0);
        check("add_start_drop", 32'(bus.unit_start),  32'd0);
        check("add_sel_hold",   32'(bus.unit_sel),    32'd1);
        check("add_busy",       32'(bus.busy),        32'd0);

        // fdiv, 12-cycle latency
        offer(5'b10111, 5'd7);
        tick();
        bus.in_valid = 1'b0;
        check("fdiv_unit_sel",   32'(bus.unit_sel),   32'd2);
        check("fdiv_unit_start", 32'(bus.unit_start), 32'd1);
        check("fdiv_busy_c1",    32'(bus.busy),       32'd1);
        check("fdiv_in_ready_c1", 32'(bus.in_ready),  32'd0);
        check("fdiv_valid_c1",   32'(bus.out_valid),  32'd0);
        for (int c = 2; c <= 11; c++) begin
            tick();
            check("fdiv_valid_early", 32'(bus.out_valid), 32'd0);
            check("fdiv_in_ready",    32'(bus.in_ready),  32'd0);
        end
        tick();
        check("fdiv_valid_c12", 32'(bus.out_valid), 32'd1);
        check("fdiv_we_c12",    32'(bus.out_we),    32'd1);
        check("fdiv_rd_c12",    32'(bus.out_rd),    32'd7);
        check("fdiv_busy_c12",  32'(bus.busy),      32'd1);
        tick();
        check("fdiv_retired",   bus.retired,        32'd2);
        check("fdiv_busy_end",  32'(bus.busy),      32'd0);

        // mul with writeback stalled, then back-to-back sub
        bus.out_ready = 1'b0;
        offer(5'b11100, 5'd4);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mul_valid_c2", 32'(bus.out_valid), 32'd0);
        tick();
        for (int h = 0; h < 5; h++) begin
            check("mul_hold_valid", 32'(bus.out_valid), 32'd1);
            check("mul_hold_rd",    32'(bus.out_rd),    32'd4);
            if (h < 4) tick();
        end
        check("mul_hold_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        offer(5'b11010, 5'd5);
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_retired",    bus.retired,          32'd3);
        check("b2b_start",      32'(bus.unit_start),  32'd1);
        check("b2b_unit_opc",   32'(bus.unit_opcode), 32'h1a);
        check("b2b_sub_valid",  32'(bus.out_valid),   32'd1);
        check("b2b_sub_rd",     32'(bus.out_rd),      32'd5);
        tick();
        check("sub_retired",    bus.retired,          32'd4);

        // div flushed mid-execution
        offer(5'b11101, 5'd9);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        bus.flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("flush_busy",     32'(bus.busy),       32'd0);
        check("flush_valid",    32'(bus.out_valid),  32'd0);
        check("flush_unit_sel", 32'(bus.unit_sel),   32'd0);
        check("flush_start",    32'(bus.unit_start), 32'd0);
        check("flush_in_ready_after", 32'(bus.in_ready), 32'd1);
        check("flush_retired",  bus.retired,         32'd4);
        for (int k = 0; k < 8; k++) tick();
        check("flush_no_valid", 32'(bus.out_valid),  32'd0);
        check("flush_retired_late", bus.retired,     32'd4);

        // Branch, store, undefined: single cycle with out_we=0
        t_opc[0] = 5'b01011; t_rd[0] = 5'd1; t_sel[0] = 2'd1;
        t_opc[1] = 5'b10011; t_rd[1] = 5'd2; t_sel[1] = 2'd1;
        t_opc[2] = 5'b11111; t_rd[2] = 5'd6; t_sel[2] = 2'd0;
        for (int i = 0; i < 3; i++) begin
            offer(t_opc[i], t_rd[i]);
            tick();
            bus.in_valid = 1'b0;
            check("nowe_valid",    32'(bus.out_valid), 32'd1);
            check("nowe_we",       32'(bus.out_we),    32'd0);
            check("nowe_unit_sel", 32'(bus.unit_sel),  32'(t_sel[i]));
            check("nowe_rd",       32'(bus.out_rd),    32'(t_rd[i]));
            tick();
        end
        check("nowe_retired", bus.retired, 32'd7);

        // retired wraps from all-ones to zero
        bus.out_ready = 1'b0;
        offer(5'b11000, 5'd8);
        tick();
        bus.in_valid = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        check("wrap_preload", bus.retired, 32'hFFFF_FFFF);
        tick();
        check("wrap_held",    bus.retired, 32'hFFFF_FFFF);
        bus.out_ready = 1'b1;
        tick();
        check("wrap_retired", bus.retired, 32'd0);

        // reset during fmul execution
        offer(5'b10110, 5'd10);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("fmul_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        check("rst2_valid",    32'(bus.out_valid),   32'd0);
        check("rst2_start",    32'(bus.unit_start),  32'd0);
        check("rst2_unit_sel", 32'(bus.unit_sel),    32'd0);
        check("rst2_unit_opc", 32'(bus.unit_opcode), 32'd0);
        check("rst2_out_rd",   32'(bus.out_rd),      32'd0);
        check("rst2_out_we",   32'(bus.out_we),      32'd0);
        check("rst2_busy",     32'(bus.busy),        32'd0);
        check("rst2_retired",  bus.retired,          32'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("rst2_no_valid", 32'(bus.out_valid),   32'd0);
        check("rst2_retired_late", bus.retired,      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_sched.md
Name: ex_sched

Overview:
- Execute-stage scheduler sitting between decode and the integer ALU / floating-point FPU datapaths.
- Accepts one decoded instruction at a time over a valid/ready handshake and classifies it by opcode into a unit.
- Issues it to that unit, then models the unit's fixed multi-cycle latency with a down-counter.
- Presents a completion to writeback over a second valid/ready handshake, with a flush to abandon in-flight work.

Parameters:
- MUL_LAT, 3, cycles for integer mul (11100)
- DIV_LAT, 8, cycles for integer div (11101)
- FADD_LAT, 4, cycles for FP add/sub (10100, 10101)
- FMUL_LAT, 4, cycles for FP mul (10110)
- FDIV_LAT, 12, cycles for FP div (10111)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  abandon held/in-flight instruction
- in_valid  input  1  decode offers instruction
- in_ready  output  1  scheduler can accept this cycle
- in_opcode  input  5  instruction opcode
- in_rd  input  5  destination register index
- unit_start  output  1  one-cycle issue pulse to selected unit
- unit_sel  output  2  0 none, 1 ALU, 2 FPU
- unit_opcode  output  5  opcode held to unit
- out_valid  output  1  result ready for writeback
- out_ready  input  1  writeback accepts
- out_rd  output  5  destination of completing instruction
- out_we  output  1  register-file write enable for completion
- busy  output  1  state != IDLE
- retired  output  32  count of completed handshakes

Behaviour:
- Reset (clk edge with reset=1):
  - State IDLE, counter 0, retired 0.
  - unit_start, unit_sel, unit_opcode, out_valid, out_rd and out_we all 0.
  - in_ready=1 as soon as reset deasserts.
- States: IDLE, EXEC, DONE.
- in_ready is combinational: (state==IDLE) || (state==DONE && out_ready); forced 0 while flush=1.
- Accept occurs on in_valid && in_ready at cycle T.
  - At T+1: opcode, rd, unit and latency are registered; unit_start=1 for exactly one cycle; unit_sel and unit_opcode stay stable until the next accept or flush.
- Latency decode, LAT:
  - Integer mul/div and FP ops: their parameter.
  - All other defined opcodes: 1. This covers logic 00000-00111, add/addi/sub/subi 11000-11011, mov/memory 10000-10011, and control 01000-01110.
  - Undefined opcodes (01111, 11110, 11111): 1, with unit_sel=0.
- Transitions:
  - LAT==1: IDLE -> DONE; out_valid at T+1.
  - LAT>1: IDLE -> EXEC with counter=LAT-1. The counter decrements each EXEC cycle; at counter==1 go to DONE. out_valid is first high at T+LAT.
- DONE holds out_valid, out_rd and out_we stable until out_ready.
  - On handshake: retired increments and wraps 0xFFFFFFFF -> 0.
  - If in_valid is also high that cycle, the new instruction is accepted back-to-back (next state per its LAT).
  - Otherwise the next state is IDLE.
- out_we is 0 for:
  - Control opcodes 01000-01110.
  - Store 10011.
  - Undefined opcodes.
  - It is 1 for everything else.
- flush is highest priority:
  - Next cycle the state is IDLE, out_valid=0 and unit_start=0.
  - Counter and unit_sel clear; retired is unchanged.
  - No accept occurs in the flush cycle.
- reset beats flush; reset mid-EXEC discards the instruction with no out_valid.
- Multiple outstanding instructions never exist; the scheduler is single-entry.

Decomposition:
- Package ex_sched_pkg holds:
  - Opcode localparams for all 5-bit encodings above.
  - Unit enum (UNIT_NONE, UNIT_ALU, UNIT_FPU).
  - State enum.
  - Counter width derived as $clog2(max latency + 1).
- One combinational sub-module, ex_lat_decode: opcode -> {unit, latency, we}, parameterised with the latency parameters.
- The top level holds the FSM, counter, output registers and retired counter.

Test Plan:
- add 11000, rd=3, accepted cycle 0, out_ready=1 -> unit_start and unit_sel=1 at cycle 1; out_valid, out_rd=3, out_we=1 at cycle 1; retired=1.
- fdiv 10111, rd=7, accepted cycle 0 -> unit_sel=2 and unit_start at cycle 1; busy 1 through the handshake; out_valid first at cycle 12 with out_we=1; in_ready=0 cycles 1-11.
- mul rd=4 completes with out_ready=0 for 5 cycles -> out_valid/out_rd held 5 cycles; then out_ready=1 with in_valid (sub, rd=5) -> back-to-back accept; sub completes the next cycle; retired=2.
- div 11101 accepted, flush at cycle 4 -> state IDLE at cycle 5; out_valid never asserted; retired unchanged; in_ready=1 at cycle 5.
- Branch 01011, then store 10011, then undefined 11111 -> each completes after 1 cycle with out_we=0; unit_sel=1, 1, 0 respectively.
- retired preloaded via force to 0xFFFFFFFF, then one completion -> retired=0; reset asserted mid-EXEC of fmul -> all outputs 0 the next cycle, no completion.
